// File: rtl/ram_dp_be.sv
// ram_dp_be -- true dual-port RAM with per-byte write enables and a
// self-clearing sweep.
//
// Two symmetric ports (A, B) each accept one access per cycle while ready=1.
// Every accepted access performs a read; bytes with we[i]=1 are also written.
// The array is zeroed by a one-word-per-cycle sweep after reset and on clr.
//
// Ports:
//   clk                 single clock, rising edge
//   rst                 asynchronous, active-low reset
//   clr                 one-cycle request to zero the array (ignored mid-sweep)
//   ready               1 when accesses are accepted (no sweep running)
//   x_en                per-port access enable
//   x_we[NB-1:0]        per-port byte write enables
//   x_addr[AW-1:0]      per-port word address
//   x_din[DW-1:0]       per-port write data
//   x_dout[DW-1:0]      per-port read data, held between results
//   x_rvalid            one-cycle pulse when x_dout carries an access result
//
// Clear FSM:
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | ready=1, ports accepted, clr starts a sweep
//   ST_SWEEP | ready=0, writes zero to cnt, cnt counts 0..DEPTH-1
module ram_dp_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  output logic                    ready,
  input  logic                    a_en,
  input  logic [DATA_WIDTH/8-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_din,
  output logic [DATA_WIDTH-1:0]   a_dout,
  output logic                    a_rvalid,
  input  logic                    b_en,
  input  logic [DATA_WIDTH/8-1:0] b_we,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_din,
  output logic [DATA_WIDTH-1:0]   b_dout,
  output logic                    b_rvalid
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]          state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;

  logic                  a_acc, b_acc, a_wr, b_wr, same_addr;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_post, b_post;
  logic [NB-1:0]         a_we_cross, b_we_cross;

  logic                  a_rv1_q, a_rv1_d, b_rv1_q, b_rv1_d;
  logic [DATA_WIDTH-1:0] a_rd1_q, a_rd1_d, b_rd1_q, b_rd1_d;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- clear FSM
  // Terminal detect uses the MSB of the incremented count so the last word
  // (DEPTH-1) is written on the same edge that returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (clr) state_d = ST_SWEEP;
      end
      default: begin
        cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
        if (cnt_d[ADDR_WIDTH]) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready = (state_q == ST_IDLE);

  // ------------------------------------------------------------ port decode
  assign a_acc     = a_en & ready;
  assign b_acc     = b_en & ready;
  assign a_wr      = a_acc & (|a_we);
  assign b_wr      = b_acc & (|b_we);
  assign same_addr = (a_addr == b_addr);

  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  // Bytes the other port also writes into this port's word this cycle.
  assign a_we_cross = (b_wr && same_addr) ? b_we : '0;
  assign b_we_cross = (a_wr && same_addr) ? a_we : '0;

  // Exact post-write word: B bytes first, then A bytes on top (A wins).
  assign a_post = merge_bytes(merge_bytes(a_old, b_din, a_we_cross), a_din, a_we);
  assign b_post = merge_bytes(merge_bytes(b_old, b_din, b_we), a_din, b_we_cross);

  // ------------------------------------------------------------------ array
  // A's byte write is issued after B's so it takes precedence on overlap.
  always_ff @(posedge clk) begin
    if (state_q == ST_SWEEP) begin
      mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (b_wr && b_we[i]) mem[b_addr][i*8 +: 8] <= b_din[i*8 +: 8];
        if (a_wr && a_we[i]) mem[a_addr][i*8 +: 8] <= a_din[i*8 +: 8];
      end
    end
  end

  // ------------------------------------------------------------ read stage
  // Pure reads always see the pre-write word; writes follow RD_MODE.
  always_comb begin
    a_rv1_d = a_acc;
    a_rd1_d = a_rd1_q;
    if (a_acc) begin
      if (!a_wr)             a_rd1_d = a_old;
      else if (RD_MODE == 0) a_rd1_d = a_post;
      else if (RD_MODE == 1) a_rd1_d = a_old;
    end
  end

  always_comb begin
    b_rv1_d = b_acc;
    b_rd1_d = b_rd1_q;
    if (b_acc) begin
      if (!b_wr)             b_rd1_d = b_old;
      else if (RD_MODE == 0) b_rd1_d = b_post;
      else if (RD_MODE == 1) b_rd1_d = b_old;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rv1_q <= 1'b0;
      a_rd1_q <= '0;
      b_rv1_q <= 1'b0;
      b_rd1_q <= '0;
    end else begin
      a_rv1_q <= a_rv1_d;
      a_rd1_q <= a_rd1_d;
      b_rv1_q <= b_rv1_d;
      b_rd1_q <= b_rd1_d;
    end
  end

  // ------------------------------------------------------- optional out reg
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  a_rv2_q, a_rv2_d, b_rv2_q, b_rv2_d;
      logic [DATA_WIDTH-1:0] a_rd2_q, a_rd2_d, b_rd2_q, b_rd2_d;

      always_comb begin
        a_rv2_d = a_rv1_q;
        b_rv2_d = b_rv1_q;
        a_rd2_d = a_rv1_q ? a_rd1_q : a_rd2_q;
        b_rd2_d = b_rv1_q ? b_rd1_q : b_rd2_q;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_rv2_q <= 1'b0;
          a_rd2_q <= '0;
          b_rv2_q <= 1'b0;
          b_rd2_q <= '0;
        end else begin
          a_rv2_q <= a_rv2_d;
          a_rd2_q <= a_rd2_d;
          b_rv2_q <= b_rv2_d;
          b_rd2_q <= b_rd2_d;
        end
      end

      assign a_dout   = a_rd2_q;
      assign a_rvalid = a_rv2_q;
      assign b_dout   = b_rd2_q;
      assign b_rvalid = b_rv2_q;
    end else begin : g_noreg
      assign a_dout   = a_rd1_q;
      assign a_rvalid = a_rv1_q;
      assign b_dout   = b_rd1_q;
      assign b_rvalid = b_rv1_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be (DATA_WIDTH=32, ADDR_WIDTH=4). Expected
// values are hand-computed; RD_MODE/OUT_REG below select which variant
// of the same-port write result and latency is expected.
module tb_ram_dp_be;

  localparam int DW      = 32;
  localparam int AW      = 4;
  localparam int RD_MODE = 0;
  localparam int OUT_REG = 0;
  localparam int LAT     = (OUT_REG != 0) ? 2 : 1;

  logic          clk = 1'b0;
  logic          rst, clr, ready;
  logic          a_en, b_en, a_rvalid, b_rvalid;
  logic [3:0]    a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din, a_dout, b_dout;

  int            checks = 0;
  int            errors = 0;
  int            n;
  logic          any_rv;
  logic [31:0]   a_exp, b_exp, exp_a, exp_b;

  always #5 clk = ~clk;

  ram_dp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_MODE(RD_MODE), .OUT_REG(OUT_REG)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_rvalid(b_rvalid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Same-port write result: post-write, pre-write, or previous dout.
  function automatic logic [31:0] wr_res(input logic [31:0] pre, input logic [31:0] post,
                                         input logic [31:0] hold);
    if (RD_MODE == 0) return post;
    if (RD_MODE == 1) return pre;
    return hold;
  endfunction

  task automatic do_a(input logic [3:0] addr, input logic [31:0] din, input logic [3:0] we,
                      input logic [31:0] exp, input string tag);
    a_en = 1'b1; a_addr = addr; a_din = din; a_we = we;
    step();
    a_en = 1'b0; a_we = '0;
    repeat (LAT-1) step();
    chk({tag, "_rvalid"}, a_rvalid, 1);
    chk(tag, a_dout, exp);
    a_exp = exp;
  endtask

  task automatic do_b(input logic [3:0] addr, input logic [31:0] din, input logic [3:0] we,
                      input logic [31:0] exp, input string tag);
    b_en = 1'b1; b_addr = addr; b_din = din; b_we = we;
    step();
    b_en = 1'b0; b_we = '0;
    repeat (LAT-1) step();
    chk({tag, "_rvalid"}, b_rvalid, 1);
    chk(tag, b_dout, exp);
    b_exp = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0;
    a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
    a_exp = '0; b_exp = '0;

    // Reset values, before any clock edge
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_a_dout", a_dout, 0);
    chk("rst_b_dout", b_dout, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    step(); step();
    rst = 1'b1;

    // Post-reset sweep length
    n = 0;
    while (!ready && n < 100) begin step(); n++; end
    chk("sweep_len_por", n, 16);

    // Whole array reads zero, alternating ports
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) do_a(4'(i), 32'h0, 4'h0, 32'h0, "init_rd_a");
      else            do_b(4'(i), 32'h0, 4'h0, 32'h0, "init_rd_b");
    end

    // Byte-enable merge
    do_a(4'd3, 32'hDEADBEEF, 4'b1111, wr_res(32'h0, 32'hDEADBEEF, a_exp), "wr3_full");
    do_a(4'd3, 32'h0000AA00, 4'b0010, wr_res(32'hDEADBEEF, 32'hDEADAAEF, a_exp), "wr3_byte");
    do_a(4'd3, 32'h0, 4'h0, 32'hDEADAAEF, "rd3");

    // No access: dout held, no rvalid
    step();
    chk("hold_rvalid", a_rvalid, 0);
    chk("hold_dout", a_dout, a_exp);

    // Same-port read-during-write
    do_a(4'd5, 32'h11111111, 4'hF, wr_res(32'h0, 32'h11111111, a_exp), "wr5_first");
    do_a(4'd5, 32'h22222222, 4'hF, wr_res(32'h11111111, 32'h22222222, a_exp), "wr5_rdw");
    do_b(4'd5, 32'h0, 4'h0, 32'h22222222, "rd5");

    // Cross-port write collision on addr 7
    a_en = 1'b1; a_addr = 4'd7; a_din = 32'hAAAAAAAA; a_we = 4'b0011;
    b_en = 1'b1; b_addr = 4'd7; b_din = 32'hBBBBBBBB; b_we = 4'b0110;
    step();
    a_en = 1'b0; a_we = '0; b_en = 1'b0; b_we = '0;
    repeat (LAT-1) step();
    exp_a = wr_res(32'h0, 32'h00BBAAAA, a_exp);
    exp_b = wr_res(32'h0, 32'h00BBAAAA, b_exp);
    chk("coll_rvalid", {a_rvalid, b_rvalid}, 2'b11);
    chk("coll_a_dout", a_dout, exp_a);
    chk("coll_b_dout", b_dout, exp_b);
    a_exp = exp_a; b_exp = exp_b;
    do_a(4'd7, 32'h0, 4'h0, 32'h00BBAAAA, "rd7");

    // B reads the address A writes in the same cycle: pre-write word
    a_en = 1'b1; a_addr = 4'd9; a_din = 32'h12345678; a_we = 4'hF;
    b_en = 1'b1; b_addr = 4'd9; b_we = 4'h0;
    step();
    a_en = 1'b0; a_we = '0; b_en = 1'b0;
    repeat (LAT-1) step();
    exp_a = wr_res(32'h0, 32'h12345678, a_exp);
    chk("xrd_a_dout", a_dout, exp_a);
    chk("xrd_b_dout", b_dout, 32'h0);
    a_exp = exp_a; b_exp = 32'h0;
    do_b(4'd9, 32'h0, 4'h0, 32'h12345678, "rd9");

    // Clear sweep: write during sweep dropped, clr ignored mid-sweep
    do_a(4'd2, 32'h5A5A5A5A, 4'hF, wr_res(32'h0, 32'h5A5A5A5A, a_exp), "wr2");
    do_b(4'd2, 32'h0, 4'h0, 32'h5A5A5A5A, "rd2_pre");
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ready", ready, 0);
    a_en = 1'b1; a_addr = 4'd4; a_din = 32'hFFFFFFFF; a_we = 4'hF;
    n = 0; any_rv = 1'b0;
    while (!ready && n < 100) begin
      step();
      a_en = 1'b0; a_we = '0;
      any_rv = any_rv | a_rvalid;
      n++;
      clr = (n == 5);
    end
    clr = 1'b0;
    chk("sweep_len_clr", n, 16);
    chk("sweep_no_rvalid", any_rv, 0);
    do_a(4'd2, 32'h0, 4'h0, 32'h0, "rd2_cleared");
    do_a(4'd4, 32'h0, 4'h0, 32'h0, "rd4_dropped");

    // Reset in the middle of a sweep
    do_a(4'd3, 32'hCAFEF00D, 4'hF, wr_res(32'h0, 32'hCAFEF00D, a_exp), "wr3_cafe");
    do_a(4'd3, 32'h0, 4'h0, 32'hCAFEF00D, "rd3_cafe");
    do_b(4'd3, 32'h0, 4'h0, 32'hCAFEF00D, "rd3_cafe_b");
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (8) step();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_a_dout", a_dout, 0);
    chk("mid_rst_b_dout", b_dout, 0);
    chk("mid_rst_rvalid", {a_rvalid, b_rvalid}, 0);
    step();
    #2 rst = 1'b1;
    a_exp = '0; b_exp = '0;
    n = 0;
    while (!ready && n < 100) begin step(); n++; end
    chk("sweep_len_restart", n, 16);
    do_a(4'd3, 32'h0, 4'h0, 32'h0, "rd3_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dp_be.md
RAM_DP_BE -- requirements
Module: ram_dp_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, address width; depth = 2^ADDR_WIDTH.
REQ-003 SHALL have parameter RD_MODE, default 0, same-port read-during-write behaviour: 0 write-first, 1 read-first, 2 no-change.
REQ-004 SHALL have parameter OUT_REG, default 0; when 1, an extra output pipeline register is added.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-007 SHALL have port clr, input, 1, single-cycle request to zero the whole array.
REQ-008 SHALL have port ready, output, 1, high when the array accepts accesses, i.e. no clear sweep is running.
REQ-009 SHALL have ports a_en / b_en, input, 1, per-port access enable.
REQ-010 SHALL have ports a_we / b_we, input, DATA_WIDTH/8, per-port byte write enables; bit i covers din[8i+7:8i].
REQ-011 SHALL have ports a_addr / b_addr, input, ADDR_WIDTH, per-port word address.
REQ-012 SHALL have ports a_din / b_din, input, DATA_WIDTH, per-port write data.
REQ-013 SHALL have ports a_dout / b_dout, output, DATA_WIDTH, per-port read data.
REQ-014 SHALL have ports a_rvalid / b_rvalid, output, 1, pulse marking the cycle when dout holds the data for an accepted access.

Function
REQ-015 SHALL accept an access on a port in a cycle with en=1 and ready=1; with ready=0 the access is dropped, no write occurs and no rvalid pulse is produced.
REQ-016 SHALL write, for an accepted access, only the bytes whose we bit is 1; all other bytes keep their value.
REQ-017 SHALL perform a read for every accepted access, including accesses with we=0.
REQ-018 SHALL present read data and rvalid 1 cycle after acceptance when OUT_REG=0, and 2 cycles after when OUT_REG=1; one access per port per cycle, fully pipelined.
REQ-019 SHALL give a same-port write access the following dout:
  - RD_MODE=0: the post-write word (merged bytes).
  - RD_MODE=1: the pre-write word.
  - RD_MODE=2: dout holds its previous value; rvalid still pulses.
REQ-020 SHALL hold dout unchanged in any cycle that has no read result, until the next one.
REQ-021 SHALL resolve cross-port collisions when both ports write the same address in the same cycle byte-wise: port A wins on bytes both enable, and each port's own-only bytes are written.
REQ-022 SHALL return the pre-write word to a port reading an address the other port writes in the same cycle.
REQ-023 SHALL implement a clear FSM with states:
  - IDLE (ready=1).
  - SWEEP (ready=0): writes zero to address cnt, cnt increments from 0 to 2^ADDR_WIDTH-1, one word per cycle; after the last address, returns to IDLE on the next edge.
REQ-024 SHALL enter SWEEP on the first clock edge after rst deasserts, and on any edge where clr=1 in IDLE; clr is ignored in SWEEP.
REQ-025 SHALL make a sweep take exactly 2^ADDR_WIDTH cycles, with ready=0 throughout.
REQ-026 SHALL keep issuing rvalid/dout for reads already accepted before ready fell; the pipeline drains normally.
REQ-027 SHALL use a sweep counter exactly ADDR_WIDTH+1 bits wide; terminal detect is on its MSB, with no wrap-around re-clear.

Reset
REQ-028 SHALL, while rst=0, immediately drive a_dout=b_dout=0, a_rvalid=b_rvalid=0 and ready=0, and reset the FSM state and counter to SWEEP/0.
REQ-029 SHALL not reset array contents asynchronously; contents are zeroed by the post-reset sweep.
REQ-030 SHALL, when rst asserts mid-sweep, abort the sweep and restart it from address 0 after deassertion.

Verification (DATA_WIDTH=32, ADDR_WIDTH=4)
REQ-031 SHALL be tested as: release rst, count cycles -> ready=0 for exactly 16 cycles then 1; reading addr 0..15 returns 0x00000000.
REQ-032 SHALL be tested as: A writes 0xDEADBEEF with we=4'b1111 to addr 3, then we=4'b0010 din=0x0000AA00 -> read of addr 3 returns 0xDEADAAEF 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
REQ-033 SHALL be tested as: with addr 5 = 0x11111111, A writes 0x22222222 to addr 5 -> a_dout 0x22222222 (RD_MODE=0), 0x11111111 (RD_MODE=1), or unchanged (RD_MODE=2).
REQ-034 SHALL be tested as: A writes 0xAAAAAAAA we=4'b0011 and B writes 0xBBBBBBBB we=4'b0110, both to addr 7 in one cycle -> addr 7 = 0x00BBAAAA.
REQ-035 SHALL be tested as: pulse clr with addr 2 nonzero, and drive an A write during the sweep -> write dropped, no a_rvalid, and addr 2 reads 0 after ready returns to 1.
REQ-036 SHALL be tested as: assert rst at sweep cycle 8 -> outputs go to 0 with no clock edge; after release the sweep takes a full 16 cycles.
